// File: rtl/sprite_blit_reader.sv
// Sprite ROM blitter: walks a WxH sprite row-major, issues ROM reads under a credit limit and
// streams clipped pixels with LCD coordinates. Optional key-colour drop: SPRITE_TRANSPARENCY_EN.
module sprite_blit_reader #(
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4,
   parameter int LCD_WIDTH    = 240,
   parameter int LCD_HEIGHT   = 320
`ifdef SPRITE_TRANSPARENCY_EN
   , parameter logic [15:0] TRANSPARENT_COLOUR = 16'hF81F
`endif
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  spriteId,
   input  logic [7:0]  xOrigin,
   input  logic [8:0]  yOrigin,
   input  logic [7:0]  spriteWidth,
   input  logic [8:0]  spriteHeight,
   output logic        busy,
   output logic        done,
   output logic [3:0]  ROMId,
   output logic [15:0] ROMAddr,
   input  logic [15:0] ReadROMOut,
   output logic        pixelValid,
   input  logic        pixelReady,
   output logic [7:0]  pixelX,
   output logic [8:0]  pixelY,
   output logic [15:0] pixelData,
   output logic [1:0]  debugState
);

   // Handshake: a pixel transfers on a rising edge where pixelValid && pixelReady; while
   // pixelValid && !pixelReady the pixel fields hold their value and pixelValid stays high.

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [7:0] DEPTH8 = 8'(FIFO_DEPTH);
   localparam logic [8:0] LCD_W9 = 9'(LCD_WIDTH);
   localparam logic [9:0] LCD_H10 = 10'(LCD_HEIGHT);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic       v;
      logic [7:0] x;
      logic [8:0] y;
      logic       clip;
   } tag_t;

   typedef struct packed {
      logic [7:0]  x;
      logic [8:0]  y;
      logic [15:0] d;
   } pix_t;

   state_t      state;
   logic [7:0]  wLat, xLat, colCnt;
   logic [8:0]  hLat, yLat, rowCnt;
   tag_t        launchQ;
   tag_t        tagQ [READ_LATENCY];
   pix_t        mem [FIFO_DEPTH];
   logic [PW-1:0] wrPtr, rdPtr;
   logic [7:0]  occ;

   logic        launch, lastCol, lastPix, credit, keep, pop, drainDone, zeroSize, clip;
   logic [7:0]  curCol, curW, curXo, inflight;
   logic [8:0]  curRow, curH, curYo, xSum;
   logic [9:0]  ySum;
   tag_t        exitTag;

   function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign debugState = state;
   assign pixelValid = (occ != 8'd0);
   assign pixelX     = mem[rdPtr].x;
   assign pixelY     = mem[rdPtr].y;
   assign pixelData  = mem[rdPtr].d;

   always_comb begin
      inflight = {7'd0, launchQ.v};
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + {7'd0, tagQ[i].v};
      end
      exitTag = tagQ[READ_LATENCY-1];
      pop     = pixelValid && pixelReady;
      keep    = exitTag.v && !exitTag.clip;
`ifdef SPRITE_TRANSPARENCY_EN
      keep    = keep && (ReadROMOut != TRANSPARENT_COLOUR);
`endif
      // A slot freed by this cycle's pop is reusable, keeping 1 pixel/clock when streaming.
      credit    = (inflight + occ) < (DEPTH8 + {7'd0, pop});
      drainDone = (inflight == 8'd0) && ((occ == 8'd0) || ((occ == 8'd1) && pop));
      zeroSize  = (spriteWidth == 8'd0) || (spriteHeight == 9'd0);

      // The first read launches straight from IDLE using the live inputs.
      if (state == S_IDLE) begin
         curCol = 8'd0;
         curRow = 9'd0;
         curW   = spriteWidth;
         curH   = spriteHeight;
         curXo  = xOrigin;
         curYo  = yOrigin;
         launch = start && !zeroSize;
      end else begin
         curCol = colCnt;
         curRow = rowCnt;
         curW   = wLat;
         curH   = hLat;
         curXo  = xLat;
         curYo  = yLat;
         launch = (state == S_FETCH) && credit;
      end

      xSum    = {1'b0, curXo} + {1'b0, curCol};
      ySum    = {1'b0, curYo} + {1'b0, curRow};
      clip    = (xSum >= LCD_W9) || (ySum >= LCD_H10);
      lastCol = (curCol == curW - 8'd1);
      lastPix = lastCol && (curRow == curH - 9'd1);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         ROMId   <= '0;
         ROMAddr <= '0;
         wLat    <= '0;
         hLat    <= '0;
         xLat    <= '0;
         yLat    <= '0;
         colCnt  <= '0;
         rowCnt  <= '0;
         launchQ <= '0;
         for (int i = 0; i < READ_LATENCY; i++) tagQ[i] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wrPtr   <= '0;
         rdPtr   <= '0;
         occ     <= '0;
      end else begin
         launchQ <= '0;
         if (launch) begin
            launchQ <= {1'b1, xSum[7:0], ySum[8:0], clip};
            ROMAddr <= (state == S_IDLE) ? 16'd0 : ROMAddr + 16'd1;
            colCnt  <= lastCol ? 8'd0 : curCol + 8'd1;
            rowCnt  <= lastCol ? curRow + 9'd1 : curRow;
         end

         // The address register is the first tag stage; the word lines up with the last one.
         tagQ[0] <= launchQ;
         for (int i = 1; i < READ_LATENCY; i++) tagQ[i] <= tagQ[i-1];

         if (keep) begin
            mem[wrPtr] <= {exitTag.x, exitTag.y, ReadROMOut};
            wrPtr      <= ptrInc(wrPtr);
         end
         if (pop) rdPtr <= ptrInc(rdPtr);
         occ <= occ + {7'd0, keep} - {7'd0, pop};

         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy  <= 1'b1;
                  ROMId <= spriteId;
                  wLat  <= spriteWidth;
                  hLat  <= spriteHeight;
                  xLat  <= xOrigin;
                  yLat  <= yOrigin;
                  if (zeroSize) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else if (lastPix) begin
                     state <= S_DRAIN;
                  end else begin
                     state <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (launch && lastPix) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (drainDone) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
